// File: rtl/ntps_mdio_master_if.sv
// AXI4-Lite register-bus bundle for ntps_mdio_master.
// The master modport is the bus initiator; the slave modport is the MDIO register block.
interface ntps_mdio_master_if;
    logic [4:0]  s_axi_awaddr;
    logic        s_axi_awvalid;
    logic        s_axi_awready;
    logic [31:0] s_axi_wdata;
    logic [3:0]  s_axi_wstrb;
    logic        s_axi_wvalid;
    logic        s_axi_wready;
    logic [1:0]  s_axi_bresp;
    logic        s_axi_bvalid;
    logic        s_axi_bready;
    logic [4:0]  s_axi_araddr;
    logic        s_axi_arvalid;
    logic        s_axi_arready;
    logic [31:0] s_axi_rdata;
    logic [1:0]  s_axi_rresp;
    logic        s_axi_rvalid;
    logic        s_axi_rready;

    modport master (
        output s_axi_awaddr, s_axi_awvalid, s_axi_wdata, s_axi_wstrb, s_axi_wvalid,
               s_axi_bready, s_axi_araddr, s_axi_arvalid, s_axi_rready,
        input  s_axi_awready, s_axi_wready, s_axi_bresp, s_axi_bvalid,
               s_axi_arready, s_axi_rdata, s_axi_rresp, s_axi_rvalid
    );

    modport slave (
        input  s_axi_awaddr, s_axi_awvalid, s_axi_wdata, s_axi_wstrb, s_axi_wvalid,
               s_axi_bready, s_axi_araddr, s_axi_arvalid, s_axi_rready,
        output s_axi_awready, s_axi_wready, s_axi_bresp, s_axi_bvalid,
               s_axi_arready, s_axi_rdata, s_axi_rresp, s_axi_rvalid
    );
endinterface

// File: rtl/ntps_mdio_master.sv
// AXI4-Lite controlled Clause-22 MDIO master serving NUM_PORTS PHY ports from one shared MDC.
// Optional: define NTPS_MDIO_PREAMBLE_SUPPRESS_EN to let CTRL[2] skip the 32-bit preamble.
module ntps_mdio_master #(
    parameter int          NUM_PORTS = 4,
    parameter int          CLK_DIV   = 50,
    parameter logic [31:0] VERSION   = 32'h0001_0000
) (
    input  logic                 axi_aclk,
    input  logic                 axi_aresetn,
    ntps_mdio_master_if.slave    s_axi,
    output logic                 mdc,
    output logic [NUM_PORTS-1:0] mdio_o,
    output logic [NUM_PORTS-1:0] mdio_t,
    input  logic [NUM_PORTS-1:0] mdio_i
);

    localparam int               DIV_W    = $clog2(CLK_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

`ifdef NTPS_MDIO_PREAMBLE_SUPPRESS_EN
    localparam bit          PRE_SUPPRESS = 1'b1;
    localparam logic [31:0] CTRL_MASK    = 32'h1F1F_0F06;
`else
    localparam bit          PRE_SUPPRESS = 1'b0;
    localparam logic [31:0] CTRL_MASK    = 32'h1F1F_0F02;
`endif

    localparam logic [2:0] ADDR_CTRL    = 3'd0;
    localparam logic [2:0] ADDR_WDATA   = 3'd1;
    localparam logic [2:0] ADDR_RDATA   = 3'd2;
    localparam logic [2:0] ADDR_STATUS  = 3'd3;
    localparam logic [2:0] ADDR_VERSION = 3'd4;

    typedef enum logic [2:0] {IDLE, PRE, HDR, TA, DATA, FIN} state_t;

    state_t             state;
    logic [DIV_W-1:0]   div_cnt;
    logic [5:0]         bit_cnt;
    logic [62:0]        frame_sr;
    logic [15:0]        rd_sr;
    logic [3:0]         port_q;
    logic               op_q;
    logic               busy;
    logic               done;
    logic               err;
    logic [31:0]        ctrl_q;
    logic [15:0]        wdata_q;
    logic [15:0]        rdata_q;

    logic               wr_fire;
    logic               rd_fire;
    logic [2:0]         wr_addr;
    logic [31:0]        wr_data;
    logic               start_req;
    logic               start_bad;
    logic               skip_pre;
    logic [63:0]        new_frame;
    logic [63:0]        start_frame;
    logic [NUM_PORTS-1:0] new_oh;
    logic [NUM_PORTS-1:0] sel_oh;
    logic               sel_in;
    logic [31:0]        rd_mux;
    logic               unused_bits;

    function automatic logic [NUM_PORTS-1:0] port_onehot(input logic [3:0] port);
        logic [NUM_PORTS-1:0] oh;
        oh = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (port == 4'(p)) oh[p] = 1'b1;
        end
        return oh;
    endfunction

    assign wr_fire   = s_axi.s_axi_awready & s_axi.s_axi_awvalid & s_axi.s_axi_wvalid;
    assign rd_fire   = s_axi.s_axi_arready & s_axi.s_axi_arvalid;
    assign wr_addr   = s_axi.s_axi_awaddr[4:2];
    assign wr_data   = s_axi.s_axi_wdata;
    assign start_req = wr_fire && (wr_addr == ADDR_CTRL) && wr_data[0];
    assign start_bad = busy || ({28'd0, wr_data[11:8]} >= 32'(NUM_PORTS));
    assign skip_pre  = PRE_SUPPRESS && wr_data[2];
    assign new_oh    = port_onehot(wr_data[11:8]);
    assign sel_oh    = port_onehot(port_q);
    assign sel_in    = |(mdio_i & sel_oh);

    // Read frames carry ones through TA and DATA so the released line idles high.
    assign new_frame = {32'hFFFF_FFFF, 2'b01, (wr_data[1] ? 2'b10 : 2'b01),
                        wr_data[20:16], wr_data[28:24],
                        (wr_data[1] ? 18'h3_FFFF : {2'b10, wdata_q})};
    assign start_frame = skip_pre ? {new_frame[31:0], 32'hFFFF_FFFF} : new_frame;

    assign s_axi.s_axi_bresp = 2'b00;
    assign s_axi.s_axi_rresp = 2'b00;
    assign unused_bits = ^{s_axi.s_axi_wstrb, s_axi.s_axi_awaddr[1:0], s_axi.s_axi_araddr[1:0]};

    // NOTE: every variable gets a default before the case so no latch is inferred.
    always_comb begin
        rd_mux = '0;
        case (s_axi.s_axi_araddr[4:2])
            ADDR_CTRL:    rd_mux = ctrl_q;
            ADDR_WDATA:   rd_mux = {16'd0, wdata_q};
            ADDR_RDATA:   rd_mux = {16'd0, rdata_q};
            ADDR_STATUS:  rd_mux = {29'd0, err, done, busy};
            ADDR_VERSION: rd_mux = VERSION;
            default:      rd_mux = '0;
        endcase
    end

    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            s_axi.s_axi_awready <= 1'b0;
            s_axi.s_axi_wready  <= 1'b0;
            s_axi.s_axi_bvalid  <= 1'b0;
            s_axi.s_axi_arready <= 1'b0;
            s_axi.s_axi_rvalid  <= 1'b0;
            s_axi.s_axi_rdata   <= '0;
        end else begin
            s_axi.s_axi_awready <= s_axi.s_axi_awvalid && s_axi.s_axi_wvalid &&
                                   !s_axi.s_axi_bvalid && !s_axi.s_axi_awready;
            s_axi.s_axi_wready  <= s_axi.s_axi_awvalid && s_axi.s_axi_wvalid &&
                                   !s_axi.s_axi_bvalid && !s_axi.s_axi_awready;
            if (wr_fire)                 s_axi.s_axi_bvalid <= 1'b1;
            else if (s_axi.s_axi_bready) s_axi.s_axi_bvalid <= 1'b0;

            s_axi.s_axi_arready <= s_axi.s_axi_arvalid && !s_axi.s_axi_rvalid && !s_axi.s_axi_arready;
            if (rd_fire) begin
                s_axi.s_axi_rvalid <= 1'b1;
                s_axi.s_axi_rdata  <= rd_mux;
            end else if (s_axi.s_axi_rready) begin
                s_axi.s_axi_rvalid <= 1'b0;
            end
        end
    end

    // NOTE: register writes come first; the later non-blocking sets of done/err win a same-cycle W1C.
    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            state    <= IDLE;
            div_cnt  <= '0;
            bit_cnt  <= '0;
            frame_sr <= '0;
            rd_sr    <= '0;
            port_q   <= '0;
            op_q     <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
            ctrl_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            mdc      <= 1'b0;
            mdio_o   <= '1;
            mdio_t   <= '1;
        end else begin
            if (wr_fire) begin
                case (wr_addr)
                    ADDR_CTRL:   ctrl_q  <= wr_data & CTRL_MASK;
                    ADDR_WDATA:  wdata_q <= wr_data[15:0];
                    ADDR_STATUS: begin
                        if (wr_data[1]) done <= 1'b0;
                        if (wr_data[2]) err  <= 1'b0;
                    end
                    default: ;
                endcase
            end

            case (state)
                IDLE: ;
                FIN: begin
                    state   <= IDLE;
                    div_cnt <= '0;
                end
                default: begin
                    if (div_cnt != DIV_LAST) begin
                        div_cnt <= div_cnt + 1'b1;
                    end else begin
                        div_cnt <= '0;
                        mdc     <= ~mdc;
                        if (!mdc) begin
                            if (op_q && state == DATA) rd_sr <= {rd_sr[14:0], sel_in};
                        end else if (bit_cnt == 6'd63) begin
                            state  <= FIN;
                            mdio_o <= '1;
                            mdio_t <= '1;
                            busy   <= 1'b0;
                            done   <= 1'b1;
                            if (op_q) rdata_q <= rd_sr;
                        end else begin
                            // Falling MDC edge: advance to the next frame bit.
                            bit_cnt  <= bit_cnt + 1'b1;
                            frame_sr <= {frame_sr[61:0], 1'b1};
                            mdio_o   <= frame_sr[62] ? '1 : ~sel_oh;
                            mdio_t   <= (op_q && bit_cnt >= 6'd45) ? '1 : ~sel_oh;
                            if (bit_cnt == 6'd31)      state <= HDR;
                            else if (bit_cnt == 6'd45) state <= TA;
                            else if (bit_cnt == 6'd47) state <= DATA;
                        end
                    end
                end
            endcase

            // Placed after the FSM case so a start accepted during FIN overrides the return to IDLE.
            if (start_req) begin
                if (start_bad) begin
                    err <= 1'b1;
                end else begin
                    state    <= skip_pre ? HDR : PRE;
                    busy     <= 1'b1;
                    port_q   <= wr_data[11:8];
                    op_q     <= wr_data[1];
                    frame_sr <= start_frame[62:0];
                    bit_cnt  <= skip_pre ? 6'd32 : 6'd0;
                    div_cnt  <= '0;
                    mdc      <= 1'b0;
                    rd_sr    <= '0;
                    mdio_o   <= start_frame[63] ? '1 : ~new_oh;
                    mdio_t   <= ~new_oh;
                end
            end
        end
    end

endmodule

// File: tb/tb_ntps_mdio_master.sv
// Directed self-checking bench for ntps_mdio_master (NUM_PORTS = 4, CLK_DIV = 4).
// Frames are captured at each observed MDC rise and compared with hand-computed bit patterns.
module tb_ntps_mdio_master;
    localparam int NUM_PORTS = 4;
    localparam int CLK_DIV   = 4;
    localparam logic [4:0] A_CTRL    = 5'h00;
    localparam logic [4:0] A_WDATA   = 5'h04;
    localparam logic [4:0] A_RDATA   = 5'h08;
    localparam logic [4:0] A_STATUS  = 5'h0C;
    localparam logic [4:0] A_VERSION = 5'h10;

    logic       clk;
    logic       rst_n;
    logic       mdc;
    logic [3:0] mdio_o;
    logic [3:0] mdio_t;
    logic [3:0] mdio_i;

    int n_checks;
    int n_pass;

    ntps_mdio_master_if axi ();

    ntps_mdio_master #(
        .NUM_PORTS(NUM_PORTS),
        .CLK_DIV  (CLK_DIV),
        .VERSION  (32'h0001_0000)
    ) dut (
        .axi_aclk   (clk),
        .axi_aresetn(rst_n),
        .s_axi      (axi),
        .mdc        (mdc),
        .mdio_o     (mdio_o),
        .mdio_t     (mdio_t),
        .mdio_i     (mdio_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish, observed timeout, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    endtask

    task automatic axi_write(input logic [4:0] addr, input logic [31:0] data);
        int t;
        @(negedge clk);
        axi.s_axi_awaddr  = addr;
        axi.s_axi_wdata   = data;
        axi.s_axi_awvalid = 1'b1;
        axi.s_axi_wvalid  = 1'b1;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!axi.s_axi_awready && t < 20);
        if (!axi.s_axi_awready) check("aw_timeout", 64'd0, 64'd1);
        @(negedge clk);
        axi.s_axi_awvalid = 1'b0;
        axi.s_axi_wvalid  = 1'b0;
    endtask

    task automatic axi_read(input logic [4:0] addr, output logic [31:0] data);
        int t;
        @(negedge clk);
        axi.s_axi_araddr  = addr;
        axi.s_axi_arvalid = 1'b1;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!axi.s_axi_arready && t < 20);
        if (!axi.s_axi_arready) check("ar_timeout", 64'd0, 64'd1);
        @(negedge clk);
        axi.s_axi_arvalid = 1'b0;
        t = 0;
        while (!axi.s_axi_rvalid && t < 20) begin
            @(negedge clk);
            t++;
        end
        if (!axi.s_axi_rvalid) check("r_timeout", 64'd0, 64'd1);
        data = axi.s_axi_rdata;
    endtask

    task automatic poll_idle(output logic [31:0] st);
        int n;
        n = 0;
        axi_read(A_STATUS, st);
        while (st[0] && n < 300) begin
            axi_read(A_STATUS, st);
            n++;
        end
        if (st[0]) check("busy_timeout", 64'd1, 64'd0);
    endtask

    // Records mdio_o/mdio_t of one port at each MDC rise and plays a PHY driving phy_data on reads.
    task automatic capture(input int port, input int nbits, input logic [15:0] phy_data,
                           output logic [63:0] o_bits, output logic [63:0] t_bits,
                           output int first_rise, output int period, output int last_rise,
                           output bit others_ok, output bit got_all);
        logic prev;
        int   k;
        int   cyc;
        int   idx;
        o_bits = '0;
        t_bits = '0;
        k = 0;
        cyc = 0;
        prev = mdc;
        others_ok = 1'b1;
        first_rise = -1;
        period = -1;
        last_rise = -1;
        while (k < nbits && cyc < 1200) begin
            @(negedge clk);
            cyc++;
            for (int p = 0; p < NUM_PORTS; p++) begin
                if (p != port && (mdio_t[p] !== 1'b1 || mdio_o[p] !== 1'b1)) others_ok = 1'b0;
            end
            if (!prev && mdc) begin
                idx = k + 64 - nbits;
                o_bits[nbits-1-k] = mdio_o[port];
                t_bits[nbits-1-k] = mdio_t[port];
                if (k == 0) first_rise = cyc;
                if (k == 1) period = cyc - first_rise;
                last_rise = cyc;
                if (idx >= 47 && idx < 63) mdio_i[port] = phy_data[62-idx];
                k++;
            end
            prev = mdc;
        end
        mdio_i = '1;
        got_all = (k == nbits);
    endtask

    logic [31:0] rd;
    logic [63:0] o_bits;
    logic [63:0] t_bits;
    int          first_rise;
    int          period;
    int          last_rise;
    bit          others_ok;
    bit          got_all;
    bit          flag;

    initial begin
        n_checks = 0;
        n_pass   = 0;
        rst_n    = 1'b0;
        mdio_i   = '1;
        axi.s_axi_awaddr  = '0;
        axi.s_axi_awvalid = 1'b0;
        axi.s_axi_wdata   = '0;
        axi.s_axi_wstrb   = 4'hF;
        axi.s_axi_wvalid  = 1'b0;
        axi.s_axi_bready  = 1'b1;
        axi.s_axi_araddr  = '0;
        axi.s_axi_arvalid = 1'b0;
        axi.s_axi_rready  = 1'b1;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_mdc",     {63'd0, mdc}, 64'd0);
        check("rst_mdio_o",  {60'd0, mdio_o}, 64'hF);
        check("rst_mdio_t",  {60'd0, mdio_t}, 64'hF);
        check("rst_awready", {63'd0, axi.s_axi_awready}, 64'd0);
        check("rst_bvalid",  {63'd0, axi.s_axi_bvalid}, 64'd0);
        check("rst_rvalid",  {63'd0, axi.s_axi_rvalid}, 64'd0);
        check("rst_rdata",   {32'd0, axi.s_axi_rdata}, 64'd0);
        rst_n = 1'b1;

        axi_read(A_VERSION, rd);  check("version", {32'd0, rd}, 64'h0001_0000);
        axi_read(A_STATUS, rd);   check("status_after_reset", {32'd0, rd}, 64'd0);
        axi_read(5'h1C, rd);      check("unmapped_read", {32'd0, rd}, 64'd0);

        axi_write(A_CTRL, 32'h0000_0004);
        axi_read(A_CTRL, rd);
`ifdef NTPS_MDIO_PREAMBLE_SUPPRESS_EN
        check("ctrl_bit2_readback", {32'd0, rd}, 64'h4);
`else
        check("ctrl_bit2_readback", {32'd0, rd}, 64'h0);
`endif

        // Write frame on port 2
        axi_write(A_WDATA, 32'h0000_A5C3);
        axi_read(A_WDATA, rd);  check("wdata_readback", {32'd0, rd}, 64'hA5C3);
        axi_write(A_CTRL, 32'h0401_0201);
        capture(2, 64, 16'h0000, o_bits, t_bits, first_rise, period, last_rise, others_ok, got_all);
        check("wr_got_all",    {63'd0, got_all}, 64'd1);
        check("wr_frame_o",    o_bits, 64'hFFFF_FFFF_5092_A5C3);
        check("wr_frame_t",    t_bits, 64'd0);
        check("wr_first_rise", 64'(first_rise), 64'd4);
        check("wr_mdc_period", 64'(period), 64'd8);
        check("wr_last_rise",  64'(last_rise), 64'd508);
        check("wr_others_rel", {63'd0, others_ok}, 64'd1);
        poll_idle(rd);
        check("wr_status_done", {32'd0, rd}, 64'h2);
        check("wr_end_mdc",     {63'd0, mdc}, 64'd0);
        check("wr_end_release", {60'd0, mdio_t}, 64'hF);
        axi_read(A_CTRL, rd);   check("ctrl_readback", {32'd0, rd}, 64'h0401_0200);
        axi_write(A_STATUS, 32'h2);
        axi_read(A_STATUS, rd); check("done_w1c", {32'd0, rd}, 64'd0);

        // Read frame on port 1, PHY returns BEEF
        axi_write(A_CTRL, 32'h0203_0103);
        capture(1, 64, 16'hBEEF, o_bits, t_bits, first_rise, period, last_rise, others_ok, got_all);
        check("rd_got_all",    {63'd0, got_all}, 64'd1);
        check("rd_frame_o",    o_bits, 64'hFFFF_FFFF_618B_FFFF);
        check("rd_frame_t",    t_bits, 64'h0000_0000_0003_FFFF);
        check("rd_others_rel", {63'd0, others_ok}, 64'd1);
        poll_idle(rd);
        check("rd_status_done", {32'd0, rd}, 64'h2);
        axi_read(A_RDATA, rd);  check("rd_rdata", {32'd0, rd}, 64'hBEEF);
        axi_write(A_STATUS, 32'h2);

        // Start while busy
        axi_write(A_CTRL, 32'h0401_0301);
        axi_read(A_STATUS, rd); check("busy_set", {32'd0, rd}, 64'h1);
        axi_write(A_CTRL, 32'h0203_0003);
        flag = 1'b1;
        for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            if (mdio_t[0] !== 1'b1 || mdio_o[0] !== 1'b1) flag = 1'b1 ^ flag ^ flag;
            if (mdio_t[0] !== 1'b1 || mdio_o[0] !== 1'b1) flag = 1'b0;
        end
        check("busy_port0_released", {63'd0, flag}, 64'd1);
        axi_read(A_STATUS, rd); check("busy_status_err_done", {32'd0, rd}, 64'h6);
        axi_read(A_RDATA, rd);  check("busy_rdata_kept", {32'd0, rd}, 64'hBEEF);
        axi_write(A_STATUS, 32'h6);
        axi_read(A_STATUS, rd); check("status_w1c_both", {32'd0, rd}, 64'd0);

        // Port out of range
        axi_write(A_CTRL, 32'h0401_0401);
        flag = 1'b1;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (mdc !== 1'b0 || mdio_t !== 4'hF) flag = 1'b0;
        end
        check("oor_no_activity", {63'd0, flag}, 64'd1);
        axi_read(A_STATUS, rd); check("oor_status_err", {32'd0, rd}, 64'h4);
        axi_write(A_STATUS, 32'h4);

        // Reset during DATA phase, then a fresh read frame
        axi_write(A_CTRL, 32'h0401_0201);
        repeat (400) @(negedge clk);
        check("pre_reset_driven", {63'd0, mdio_t[2]}, 64'd0);
        rst_n = 1'b0;
        #1;
        check("midrst_mdc",    {63'd0, mdc}, 64'd0);
        check("midrst_mdio_t", {60'd0, mdio_t}, 64'hF);
        check("midrst_mdio_o", {60'd0, mdio_o}, 64'hF);
        @(negedge clk);
        rst_n = 1'b1;
        axi_read(A_STATUS, rd); check("midrst_status", {32'd0, rd}, 64'd0);
        axi_write(A_CTRL, 32'h0203_0103);
        capture(1, 64, 16'h1234, o_bits, t_bits, first_rise, period, last_rise, others_ok, got_all);
        check("post_rst_frame_o", o_bits, 64'hFFFF_FFFF_618B_FFFF);
        poll_idle(rd);
        check("post_rst_done", {32'd0, rd}, 64'h2);
        axi_read(A_RDATA, rd);  check("post_rst_rdata", {32'd0, rd}, 64'h1234);
        axi_write(A_STATUS, 32'h2);

`ifdef NTPS_MDIO_PREAMBLE_SUPPRESS_EN
        // Preamble-suppressed read frame: 32 MDC periods starting with ST = 0
        axi_write(A_CTRL, 32'h0203_0107);
        capture(1, 32, 16'hC0DE, o_bits, t_bits, first_rise, period, last_rise, others_ok, got_all);
        check("np_got_all",    {63'd0, got_all}, 64'd1);
        check("np_frame_o",    o_bits, 64'h0000_0000_618B_FFFF);
        check("np_frame_t",    t_bits, 64'h0000_0000_0003_FFFF);
        check("np_first_rise", 64'(first_rise), 64'd4);
        check("np_last_rise",  64'(last_rise), 64'd252);
        poll_idle(rd);
        check("np_done", {32'd0, rd}, 64'h2);
        axi_read(A_RDATA, rd);  check("np_rdata", {32'd0, rd}, 64'hC0DE);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/ntps_mdio_master.md
Name: ntps_mdio_master

Overview:
- AXI4-Lite-controlled Clause-22 MDIO master driving NUM_PORTS independent PHY management ports from one shared MDC.
- Next-generation replacement for the single Ethernet-lite MDIO path plus tristate-merge mux. Each port gets its own mdio_o/mdio_t/mdio_i triple.
- Frames are issued by register write. Completion is reported by status bits.
- Sits on one AXI-Lite master slot of the PCIe-AXI bridge in the interfaces level.

Parameters:
NUM_PORTS, 4, number of PHY MDIO ports (1..16)
CLK_DIV, 50, MDC half-period in axi_aclk cycles (>=2)
VERSION, 32'h0001_0000, value returned by VERSION register

Ports:
axi_aclk  in  1  system clock
axi_aresetn  in  1  asynchronous active-low reset
s_axi_awaddr  in  5  write address (byte address, word aligned)
s_axi_awvalid  in  1  write address valid
s_axi_awready  out  1  write address ready
s_axi_wdata  in  32  write data
s_axi_wstrb  in  4  write strobes (ignored, full-word writes)
s_axi_wvalid  in  1  write data valid
s_axi_wready  out  1  write data ready
s_axi_bresp  out  2  write response, always 2'b00
s_axi_bvalid  out  1  write response valid
s_axi_bready  in  1  write response ready
s_axi_araddr  in  5  read address
s_axi_arvalid  in  1  read address valid
s_axi_arready  out  1  read address ready
s_axi_rdata  out  32  read data
s_axi_rresp  out  2  read response, always 2'b00
s_axi_rvalid  out  1  read data valid
s_axi_rready  in  1  read data ready
mdc  out  1  shared management clock, idle low
mdio_o  out  NUM_PORTS  per-port MDIO output data
mdio_t  out  NUM_PORTS  per-port tristate enable, 1 = released
mdio_i  in  NUM_PORTS  per-port MDIO input data

Behaviour:
Clock and reset:
- Single clock domain: axi_aclk, asynchronous active-low reset axi_aresetn.
- Reset values: all ready/valid outputs 0, bresp/rresp 0, rdata 0, mdc 0, mdio_o all 1, mdio_t all 1, all registers 0, FSM IDLE.

AXI write channel:
- awready and wready pulse high together for one cycle when awvalid & wvalid & !bvalid.
- bvalid rises the following cycle and holds until bready.

AXI read channel:
- arready pulses for one cycle when arvalid & !rvalid.
- rdata/rvalid are registered the next cycle; rvalid holds until rready.
- Unmapped addresses: reads return 0, writes are ignored, response is OKAY.

Register map:
- 0x00 CTRL (W): [0] start, [1] op (1 = read, 0 = write), [2] no_preamble (see Optional Feature), [11:8] port, [20:16] phyad, [28:24] regad. Reads return the last written value with [0] = 0.
- 0x04 WDATA [15:0].
- 0x08 RDATA [15:0] (RO).
- 0x0C STATUS: [0] busy (RO), [1] done (sticky, W1C), [2] err (sticky, W1C).
- 0x10 VERSION (RO).

Start rules:
- A start with busy = 1, or with port >= NUM_PORTS, is ignored and sets err.
- Otherwise the FSM latches all fields and sets busy in the cycle after the write handshake.

FSM states: IDLE -> PRE -> HDR -> TA -> DATA -> FIN -> IDLE.

MDC timing:
- Divider counts 0..CLK_DIV-1; each wrap toggles mdc. Period = 2*CLK_DIV cycles.
- The divider runs only outside IDLE and restarts from 0 with mdc = 0 on entry to PRE (or HDR).
- mdio_o/mdio_t of the selected port change only in the cycle mdc falls (and on FSM entry). mdio_i is sampled in the cycle mdc rises.
- One bit per MDC period; first bit is driven on FSM entry.

Frame content:
- PRE: 32 ones.
- HDR: ST = 01, OP (10 = read, 01 = write), PHYAD[4:0], REGAD[4:0], MSB first, 14 bits.
- TA, write: drive 1,0.
- TA, read: mdio_t = 1 for both bits.
- DATA: 16 bits, MSB first. Write drives WDATA; read keeps mdio_t = 1 and shifts sampled mdio_i in.

Frame end:
- FIN is entered after the 64th (or 32nd) MDC rising edge.
- In FIN: mdc low, selected port released (mdio_t = 1, mdio_o = 1), RDATA updated (reads only), busy cleared, done set. Next cycle returns to IDLE.

Port isolation:
- Non-selected ports hold mdio_t = 1, mdio_o = 1 throughout.

Simultaneous events:
- A W1C of done in the same cycle as FIN leaves done = 1 (set wins).
- A W1C of err in the same cycle as an error-causing start leaves err = 1.

Reset mid-frame:
- Immediately returns to reset values.
- mdc low, all ports released, no done set.

Optional Feature:
Macro: NTPS_MDIO_PREAMBLE_SUPPRESS_EN
- Defined: CTRL[2] = 1 skips PRE. The FSM enters HDR directly, so the frame is 32 MDC periods. CTRL[2] reads back as written.
- Undefined: CTRL[2] is ignored, reads 0, and every frame includes the 32-bit preamble.

Test Plan:
- Write: NUM_PORTS = 4, CLK_DIV = 4. Write WDATA = 16'hA5C3, then CTRL = port 2, phyad 5'h01, regad 5'h04, op 0, start. Required: port 2 serialises 32×1, 01 01 00001 00100 10, A5C3. mdc period = 8 cycles. Ports 0/1/3 stay released. busy high for 64 MDC periods, then done = 1.
- Read: PHY model on port 1 drives 16'hBEEF after TA. CTRL = port 1, op 1, start. Required: mdio_t(1) = 1 from the first TA bit through the end of the frame. RDATA reads 16'hBEEF after done.
- Start while busy: issue a second start mid-frame. Required: first frame completes unchanged and err = 1. Writing STATUS = 32'h6 clears done and err.
- Port out of range: port = 4. Required: no mdc activity, busy stays 0, err = 1.
- Reset mid-frame: deassert axi_aresetn during the DATA phase. Required: same cycle gives mdc = 0, all mdio_t = 1, busy = 0, done = 0. A new frame then runs normally.
- Macro defined, CTRL[2] = 1: required frame length is 32 MDC periods, the first bit driven is ST 0, and RDATA is correct.
